// File: rtl/ones_complement_checksum_engine_pkg.sv
// rtl/ones_complement_checksum_engine_pkg.sv - shared widths, state encoding and ones-complement add
package ones_complement_checksum_engine_pkg;

   localparam int WORD_W    = 16;
   localparam int LANE_CNT  = 4;

   typedef enum logic {
      ACCUM  = 1'b0,
      RESULT = 1'b1
   } state_t;

   // End-around carry add; one fold of the carry is enough because a+b <= 2*(2^W-1).
   function automatic logic [WORD_W-1:0] oc_add(input logic [WORD_W-1:0] a,
                                                 input logic [WORD_W-1:0] b);
      logic [WORD_W:0] t;
      t = {1'b0, a} + {1'b0, b};
      return t[WORD_W-1:0] + {{(WORD_W-1){1'b0}}, t[WORD_W]};
   endfunction

endpackage

// File: rtl/ones_complement_checksum_engine_adders.sv
// rtl/ones_complement_checksum_engine_adders.sv - two-operand and multi-operand ones-complement adders
module ones_complement_addition #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum
);

   logic [WIDTH:0] raw;

   assign raw = {1'b0, a} + {1'b0, b};
   assign sum = raw[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, raw[WIDTH]};

endmodule

module ones_complement_sum #(
   parameter int WIDTH         = 16,
   parameter int OPERAND_COUNT = 4
) (
   input  logic [WIDTH*OPERAND_COUNT-1:0] operands,
   output logic [WIDTH-1:0]               sum
);

   logic [WIDTH:0]   raw;
   logic [WIDTH-1:0] run;

   // Sequential fold; each step re-absorbs its carry so the chain never widens.
   always_comb begin
      raw = '0;
      run = '0;
      for (int i = 0; i < OPERAND_COUNT; i++) begin
         raw = {1'b0, run} + {1'b0, operands[i*WIDTH +: WIDTH]};
         run = raw[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, raw[WIDTH]};
      end
   end

   assign sum = run;

endmodule

// File: rtl/ones_complement_checksum_engine.sv
// rtl/ones_complement_checksum_engine.sv - streaming ones-complement checksum with result handshake
module ones_complement_checksum_engine
   import ones_complement_checksum_engine_pkg::*;
#(
   parameter  int WIDTH     = 16,
   parameter  int LANES     = 4,
   parameter  int MAX_BEATS = 16,
   localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [WIDTH*LANES-1:0] s_data,
   input  logic [LANES-1:0]       s_keep,
   input  logic                   s_last,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [WIDTH-1:0]       m_checksum,
   output logic                   m_ok,
   output logic [CNT_W-1:0]       m_beats,
   output logic                   m_error
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

   state_t                 state_q, state_d;
   logic [WIDTH-1:0]       acc_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   ovf_q;
   logic [WIDTH*LANES-1:0] masked;
   logic [WIDTH-1:0]       beat_sum;
   logic [WIDTH-1:0]       acc_next;
   logic                   beat_fire;
   logic                   at_max;
   logic [CNT_W-1:0]       cnt_inc;

   always_comb begin
      masked = '0;
      for (int i = 0; i < LANES; i++) begin
         masked[i*WIDTH +: WIDTH] = s_keep[i] ? s_data[i*WIDTH +: WIDTH] : '0;
      end
   end

   ones_complement_sum #(
      .WIDTH         (WIDTH),
      .OPERAND_COUNT (LANES)
   ) u_beat_sum (
      .operands (masked),
      .sum      (beat_sum)
   );

   ones_complement_addition #(
      .WIDTH (WIDTH)
   ) u_acc_add (
      .a   (acc_q),
      .b   (beat_sum),
      .sum (acc_next)
   );

   assign s_ready   = (state_q == ACCUM);
   assign m_valid   = (state_q == RESULT);
   assign beat_fire = s_valid && (state_q == ACCUM);
   assign at_max    = (cnt_q == MAX_CNT);
   assign cnt_inc   = at_max ? MAX_CNT : cnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ACCUM:   if (s_valid && s_last) state_d = RESULT;
         RESULT:  if (m_ready)           state_d = ACCUM;
         default:                        state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ACCUM;
      end else begin
         state_q <= state_d;
      end
   end

   // Result registers are only written on the closing beat, so they hold through RESULT and beyond.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q      <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         m_checksum <= '0;
         m_ok       <= 1'b0;
         m_beats    <= '0;
         m_error    <= 1'b0;
      end else if (beat_fire) begin
         acc_q <= acc_next;
         cnt_q <= cnt_inc;
         ovf_q <= ovf_q | at_max;
         if (s_last) begin
            m_checksum <= ~acc_next;
            m_ok       <= (acc_next == {WIDTH{1'b1}});
            m_beats    <= cnt_inc;
            m_error    <= ovf_q | at_max;
         end
      end else if (state_q == RESULT && m_ready) begin
         acc_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ones_complement_checksum_engine.sv
// tb/tb_ones_complement_checksum_engine.sv - directed checks of the checksum engine
module tb_ones_complement_checksum_engine;
   import ones_complement_checksum_engine_pkg::*;

   localparam int W     = 16;
   localparam int L     = 4;
   localparam int MAXB  = 4;
   localparam int CW    = $clog2(MAXB + 1);

   logic            clk = 1'b0;
   logic            reset;
   logic            s_valid;
   logic            s_ready;
   logic [W*L-1:0]  s_data;
   logic [L-1:0]    s_keep;
   logic            s_last;
   logic            m_valid;
   logic            m_ready;
   logic [W-1:0]    m_checksum;
   logic            m_ok;
   logic [CW-1:0]   m_beats;
   logic            m_error;

   int checks = 0;
   int fails  = 0;

   ones_complement_checksum_engine #(
      .WIDTH     (W),
      .LANES     (L),
      .MAX_BEATS (MAXB)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_keep     (s_keep),
      .s_last     (s_last),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_checksum (m_checksum),
      .m_ok       (m_ok),
      .m_beats    (m_beats),
      .m_error    (m_error)
   );

   always #5 clk = ~clk;

   task automatic send_beat(input logic [W-1:0] w0, input logic [W-1:0] w1,
                            input logic [W-1:0] w2, input logic [W-1:0] w3,
                            input logic [L-1:0] keep, input logic last);
      checks++;
      if (s_ready !== 1'b1) begin
         fails++;
         $display("FAIL beat_s_ready: got %b want 1", s_ready);
      end
      s_valid = 1'b1;
      s_data  = {w3, w2, w1, w0};
      s_keep  = keep;
      s_last  = last;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_data  = {W*L{1'bx}};
      s_keep  = 'x;
      s_last  = 1'bx;
   endtask

   task automatic release_result();
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      m_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      s_keep  = '0;
      s_last  = 1'b0;
      m_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      checks++;
      if ({s_ready, m_valid, m_checksum, m_ok, m_beats, m_error} !== {1'b1, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0}) begin
         fails++;
         $display("FAIL reset_state: got rdy=%b vld=%b cs=%h ok=%b beats=%0d err=%b want rdy=1 vld=0 cs=0000 ok=0 beats=0 err=0",
                  s_ready, m_valid, m_checksum, m_ok, m_beats, m_error);
      end
   endtask

   task automatic test_ipv4_generate();
      send_beat(16'h4500, 16'h0073, 16'h0000, 16'h4000, 4'b1111, 1'b0);
      checks++;
      if (m_valid !== 1'b0) begin
         fails++;
         $display("FAIL ipv4_no_early_valid: got %b want 0", m_valid);
      end
      send_beat(16'h4011, 16'h0000, 16'hc0a8, 16'h0001, 4'b1111, 1'b0);
      send_beat(16'hc0a8, 16'h00c7, 16'hdead, 16'hbeef, 4'b0011, 1'b1);
      checks++;
      if ({m_valid, s_ready, m_checksum, m_ok, m_beats, m_error} !== {1'b1, 1'b0, 16'hB861, 1'b0, 3'd3, 1'b0}) begin
         fails++;
         $display("FAIL ipv4_gen: got vld=%b rdy=%b cs=%h ok=%b beats=%0d err=%b want vld=1 rdy=0 cs=b861 ok=0 beats=3 err=0",
                  m_valid, s_ready, m_checksum, m_ok, m_beats, m_error);
      end
      release_result();
      checks++;
      if ({m_valid, s_ready} !== 2'b01) begin
         fails++;
         $display("FAIL ipv4_release: got vld=%b rdy=%b want vld=0 rdy=1", m_valid, s_ready);
      end
   endtask

   task automatic test_ipv4_verify();
      send_beat(16'h4500, 16'h0073, 16'h0000, 16'h4000, 4'b1111, 1'b0);
      send_beat(16'h4011, 16'hB861, 16'hc0a8, 16'h0001, 4'b1111, 1'b0);
      send_beat(16'hc0a8, 16'h00c7, 16'h1111, 16'h2222, 4'b0011, 1'b1);
      checks++;
      if ({m_valid, m_checksum, m_ok, m_beats} !== {1'b1, 16'h0000, 1'b1, 3'd3}) begin
         fails++;
         $display("FAIL ipv4_verify: got vld=%b cs=%h ok=%b beats=%0d want vld=1 cs=0000 ok=1 beats=3",
                  m_valid, m_checksum, m_ok, m_beats);
      end
      release_result();
   endtask

   task automatic test_end_around_carry();
      logic [W-1:0] exp_cs;
      exp_cs = ~oc_add(16'hFFFF, 16'h0001);
      send_beat(16'hFFFF, 16'h0001, 16'h5555, 16'hAAAA, 4'b0011, 1'b1);
      checks++;
      if ({m_checksum, m_ok, m_beats} !== {16'hFFFE, 1'b0, 3'd1} || m_checksum !== exp_cs) begin
         fails++;
         $display("FAIL carry: got cs=%h ok=%b beats=%0d want cs=fffe ok=0 beats=1", m_checksum, m_ok, m_beats);
      end
      release_result();
   endtask

   task automatic test_backpressure();
      send_beat(16'h0102, 16'h0304, 16'h0506, 16'h0708, 4'b1111, 1'b1);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         checks++;
         if ({m_valid, s_ready, m_checksum, m_beats} !== {1'b1, 1'b0, 16'hEFEB, 3'd1}) begin
            fails++;
            $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b cs=%h beats=%0d want vld=1 rdy=0 cs=efeb beats=1",
                     c, m_valid, s_ready, m_checksum, m_beats);
         end
      end
      m_ready = 1'b1;
      checks++;
      if (s_ready !== 1'b0) begin
         fails++;
         $display("FAIL bp_bubble: got rdy=%b want 0", s_ready);
      end
      @(posedge clk);
      #1;
      m_ready = 1'b0;
      checks++;
      if ({s_ready, m_valid, m_checksum} !== {1'b1, 1'b0, 16'hEFEB}) begin
         fails++;
         $display("FAIL bp_after: got rdy=%b vld=%b cs=%h want rdy=1 vld=0 cs=efeb", s_ready, m_valid, m_checksum);
      end
      send_beat(16'h0100, 16'h9999, 16'h9999, 16'h9999, 4'b0001, 1'b1);
      checks++;
      if ({m_checksum, m_beats, m_error} !== {16'hFEFF, 3'd1, 1'b0}) begin
         fails++;
         $display("FAIL bp_next: got cs=%h beats=%0d err=%b want cs=feff beats=1 err=0", m_checksum, m_beats, m_error);
      end
      release_result();
   endtask

   task automatic test_overflow();
      for (int b = 0; b < 6; b++) begin
         send_beat(16'h0001, 16'h0001, 16'h0001, 16'h0001, 4'b1111, (b == 5));
      end
      checks++;
      if ({m_valid, m_checksum, m_beats, m_error} !== {1'b1, 16'hFFE7, 3'd4, 1'b1}) begin
         fails++;
         $display("FAIL overflow: got vld=%b cs=%h beats=%0d err=%b want vld=1 cs=ffe7 beats=4 err=1",
                  m_valid, m_checksum, m_beats, m_error);
      end
      release_result();
      send_beat(16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 1'b1);
      checks++;
      if ({m_checksum, m_beats, m_error} !== {16'hFFFF, 3'd1, 1'b0}) begin
         fails++;
         $display("FAIL keep_zero: got cs=%h beats=%0d err=%b want cs=ffff beats=1 err=0", m_checksum, m_beats, m_error);
      end
      release_result();
   endtask

   task automatic test_reset_mid_packet();
      send_beat(16'h1111, 16'h2222, 16'h3333, 16'h4444, 4'b1111, 1'b0);
      send_beat(16'h5555, 16'h6666, 16'h7777, 16'h8888, 4'b1111, 1'b0);
      reset = 1'b1;
      #3;
      checks++;
      if ({s_ready, m_valid, m_checksum} !== {1'b1, 1'b0, 16'h0000}) begin
         fails++;
         $display("FAIL midreset: got rdy=%b vld=%b cs=%h want rdy=1 vld=0 cs=0000", s_ready, m_valid, m_checksum);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      send_beat(16'h1234, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4'b0001, 1'b1);
      checks++;
      if ({m_valid, m_checksum, m_beats, m_error} !== {1'b1, 16'hEDCB, 3'd1, 1'b0}) begin
         fails++;
         $display("FAIL post_reset: got vld=%b cs=%h beats=%0d err=%b want vld=1 cs=edcb beats=1 err=0",
                  m_valid, m_checksum, m_beats, m_error);
      end
      release_result();
   endtask

   initial begin
      test_reset();
      test_ipv4_generate();
      test_ipv4_verify();
      test_end_around_carry();
      test_backpressure();
      test_overflow();
      test_reset_mid_packet();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
